// File: rtl/path_player_pkg.sv
// Shared definitions for the maze solver datapath and the path player.
//   - move encoding (2 bits per step)
//   - player state encoding
//   - default buffer depth and replay step period
//   - move_onehot(): 2-bit move -> {down,left,right,up} LED pattern
package path_player_pkg;

    localparam logic [1:0] MV_UP    = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    localparam int DEPTH_DEF       = 64;
    localparam int STEP_CYCLES_DEF = 50000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_READY,
        ST_PLAY,
        ST_FINISHED,
        ST_FAILED
    } state_t;

    // Move codes were chosen so that the code is the LED bit index.
    function automatic logic [3:0] move_onehot(input logic [1:0] mv);
        return 4'b0001 << mv;
    endfunction

endpackage

// File: rtl/path_buffer.sv
// Path move store: DEPTH x 2-bit register file.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - move to store
//   raddr - read address (asynchronous read)
//   rdata - move at raddr
// Contents are not reset; nothing is read before it has been written.
module path_buffer #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [1:0]       wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [1:0]       rdata
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/path_player.sv
// Path player: drains the solved path from the maze solver one move per
// run/move handshake, stores it, then replays it at a visible pace.
//   clk, rst        - clock, async active-low reset
//   solver_done/fail- solver result levels (sampled in IDLE only)
//   move, move_last - solver move, valid the cycle after run
//   run             - one-cycle request for the next move
//   replay_start    - start/restart replay (READY/FINISHED only)
//   led_dir         - one-hot current move {down,left,right,up}
//   x_pos, y_pos    - replay position, 4-bit wrapping
//   path_len        - number of captured moves
//   busy            - FETCH/CAPTURE/PLAY
//   fail, overflow  - solver failure / path too long (sticky)
//   pos_err         - replay position wrapped (sticky)
//   replay_done     - replay finished
module path_player
    import path_player_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int PTR_W       = 6,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             solver_done,
    input  logic             solver_fail,
    input  logic [1:0]       move,
    input  logic             move_last,
    output logic             run,
    input  logic             replay_start,
    output logic [3:0]       led_dir,
    output logic [3:0]       x_pos,
    output logic [3:0]       y_pos,
    output logic [PTR_W:0]   path_len,
    output logic             busy,
    output logic             fail,
    output logic             overflow,
    output logic             pos_err,
    output logic             replay_done
);

    state_t           state, state_nx;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] timer;
    logic [1:0]       cur_move;
    logic             step_end, last_step, cap_full;

    path_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_buf (
        .clk   (clk),
        .we    (state == ST_CAPTURE),
        .waddr (path_len[PTR_W-1:0]),
        .wdata (move),
        .raddr (rd_ptr),
        .rdata (cur_move)
    );

    assign step_end  = (timer == CNT_W'(STEP_CYCLES - 1));
    assign last_step = ({1'b0, rd_ptr} == path_len - (PTR_W+1)'(1));
    // The move being captured now fills the last free slot.
    assign cap_full  = (path_len == (PTR_W+1)'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (solver_fail)      state_nx = ST_FAILED;
                else if (solver_done) state_nx = ST_FETCH;
            end
            ST_FETCH:   state_nx = ST_CAPTURE;
            ST_CAPTURE: begin
                if (move_last)     state_nx = ST_READY;
                else if (cap_full) state_nx = ST_FAILED;
                else               state_nx = ST_FETCH;
            end
            ST_READY, ST_FINISHED: begin
                if (replay_start) state_nx = ST_PLAY;
            end
            ST_PLAY: begin
                if (step_end && last_step) state_nx = ST_FINISHED;
            end
            ST_FAILED: state_nx = ST_FAILED;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            path_len <= '0;
            rd_ptr   <= '0;
            timer    <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
            overflow <= 1'b0;
            pos_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!solver_fail && solver_done) path_len <= '0;
                end
                ST_CAPTURE: begin
                    path_len <= path_len + (PTR_W+1)'(1);
                    if (!move_last && cap_full) overflow <= 1'b1;
                end
                ST_READY, ST_FINISHED: begin
                    if (replay_start) begin
                        rd_ptr <= '0;
                        timer  <= '0;
                        x_pos  <= '0;
                        y_pos  <= '0;
                    end
                end
                ST_PLAY: begin
                    if (step_end) begin
                        timer  <= '0;
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        // Position arithmetic wraps mod 16; flag any wrap.
                        case (cur_move)
                            MV_UP: begin
                                y_pos <= y_pos - 4'd1;
                                if (y_pos == 4'd0) pos_err <= 1'b1;
                            end
                            MV_DOWN: begin
                                y_pos <= y_pos + 4'd1;
                                if (y_pos == 4'd15) pos_err <= 1'b1;
                            end
                            MV_RIGHT: begin
                                x_pos <= x_pos + 4'd1;
                                if (x_pos == 4'd15) pos_err <= 1'b1;
                            end
                            default: begin
                                x_pos <= x_pos - 4'd1;
                                if (x_pos == 4'd0) pos_err <= 1'b1;
                            end
                        endcase
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign run         = (state == ST_FETCH);
    assign led_dir     = (state == ST_PLAY) ? move_onehot(cur_move) : 4'b0000;
    assign busy        = (state == ST_FETCH) || (state == ST_CAPTURE) || (state == ST_PLAY);
    // FAILED is terminal, so the state itself is the sticky flag.
    assign fail        = (state == ST_FAILED);
    assign replay_done = (state == ST_FINISHED);

endmodule

// File: tb/tb_path_player.sv
// Bench for path_player with DEPTH=4, STEP_CYCLES=4. A small solver model
// answers run requests; a position/LED model built from the move list
// predicts every replay cycle.
module tb_path_player;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int S     = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0, rst = 1'b0;
    logic solver_done = 1'b0, solver_fail = 1'b0, move_last = 1'b0, replay_start = 1'b0;
    logic [1:0] move = 2'b00;
    logic run, busy, fail, overflow, pos_err, replay_done;
    logic [3:0] led_dir, x_pos, y_pos;
    logic [PTR_W:0] path_len;

    int vectors = 0, miscompares = 0;
    int mv_q[$];
    bit err_sticky = 1'b0;

    path_player #(.DEPTH(DEPTH), .PTR_W(PTR_W), .STEP_CYCLES(S), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .solver_done(solver_done), .solver_fail(solver_fail),
        .move(move), .move_last(move_last), .run(run), .replay_start(replay_start),
        .led_dir(led_dir), .x_pos(x_pos), .y_pos(y_pos), .path_len(path_len),
        .busy(busy), .fail(fail), .overflow(overflow), .pos_err(pos_err),
        .replay_done(replay_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".run"}, 32'(run), 0);
        chk({tag, ".led"}, 32'(led_dir), 0);
        chk({tag, ".x"}, 32'(x_pos), 0);
        chk({tag, ".y"}, 32'(y_pos), 0);
        chk({tag, ".len"}, 32'(path_len), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".fail"}, 32'(fail), 0);
        chk({tag, ".ovf"}, 32'(overflow), 0);
        chk({tag, ".perr"}, 32'(pos_err), 0);
        chk({tag, ".done"}, 32'(replay_done), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; solver_done = 1'b0; solver_fail = 1'b0;
        replay_start = 1'b0; move_last = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst = 1'b1;
        err_sticky = 1'b0;
    endtask

    // Solver model: a run seen in one cycle is answered with data valid in
    // the following cycle; otherwise move/move_last carry junk.
    task automatic do_capture(input int nruns, input bit ends);
        int idx = 0;
        bit pend = 1'b0;
        solver_done = 1'b1;
        for (int k = 1; k <= 2*nruns + 2; k++) begin
            @(negedge clk);
            chk("run", 32'(run), 32'((k % 2 == 1) && (k <= 2*nruns - 1)));
            if (pend && idx < mv_q.size()) begin
                move      = 2'(mv_q[idx]);
                move_last = ends && (idx == mv_q.size() - 1);
                idx++;
            end else begin
                move      = 2'($urandom);
                move_last = 1'($urandom);
            end
            pend = run;
        end
        solver_done = 1'b0;
        move_last   = 1'b0;
    endtask

    task automatic do_replay();
        int n = mv_q.size();
        int xs[$], ys[$];
        bit es[$];
        int x = 0, y = 0, i;
        bit e = err_sticky;
        logic [3:0] exp_led;
        xs.push_back(0); ys.push_back(0); es.push_back(e);
        foreach (mv_q[m]) begin
            case (mv_q[m])
                0: y = y - 1;
                3: y = y + 1;
                1: x = x + 1;
                default: x = x - 1;
            endcase
            if (x < 0 || x > 15 || y < 0 || y > 15) e = 1'b1;
            x = (x + 16) % 16;
            y = (y + 16) % 16;
            xs.push_back(x); ys.push_back(y); es.push_back(e);
        end
        replay_start = 1'b1;
        for (int j = 1; j <= n*S + 1; j++) begin
            @(negedge clk);
            replay_start = 1'b0;
            i = (j - 1) / S;
            if (i > n) i = n;
            exp_led = (j <= n*S) ? (4'b0001 << mv_q[i]) : 4'b0000;
            chk("play.led", 32'(led_dir), 32'(exp_led));
            chk("play.x", 32'(x_pos), 32'(xs[i]));
            chk("play.y", 32'(y_pos), 32'(ys[i]));
            chk("play.perr", 32'(pos_err), 32'(es[i]));
            chk("play.busy", 32'(busy), 32'(j <= n*S));
            chk("play.done", 32'(replay_done), 32'(j == n*S + 1));
        end
        err_sticky = es[n];
    endtask

    initial begin
        int n;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("por");
        rst = 1'b1;

        // right, down, down
        mv_q = '{1, 3, 3};
        do_capture(3, 1'b1);
        chk("d3.len", 32'(path_len), 3);
        chk("d3.busy", 32'(busy), 0);
        chk("d3.fail", 32'(fail), 0);
        solver_fail = 1'b1;               // ignored outside IDLE
        repeat (2) @(negedge clk);
        solver_fail = 1'b0;
        chk("d3.ign_fail", 32'(fail), 0);
        do_replay();
        chk("d3.x", 32'(x_pos), 1);
        chk("d3.y", 32'(y_pos), 2);
        chk("d3.perr", 32'(pos_err), 0);
        do_replay();                       // restart from FINISHED

        // done and fail together
        do_reset();
        solver_done = 1'b1; solver_fail = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("df.run", 32'(run), 0);
        end
        chk("df.fail", 32'(fail), 1);
        chk("df.ovf", 32'(overflow), 0);
        solver_done = 1'b0; solver_fail = 1'b0;
        replay_start = 1'b1;
        repeat (2) @(negedge clk);
        chk("df.led", 32'(led_dir), 0);
        chk("df.busy", 32'(busy), 0);
        replay_start = 1'b0;

        // overflow: move_last never comes
        do_reset();
        mv_q = {};
        repeat (6) mv_q.push_back(int'($urandom_range(0, 3)));
        do_capture(DEPTH, 1'b0);
        chk("ov.len", 32'(path_len), DEPTH);
        chk("ov.ovf", 32'(overflow), 1);
        chk("ov.fail", 32'(fail), 1);
        chk("ov.busy", 32'(busy), 0);
        replay_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("ov.led", 32'(led_dir), 0);
        chk("ov.done", 32'(replay_done), 0);
        chk("ov.run", 32'(run), 0);
        replay_start = 1'b0;

        // single up: y wraps to 15
        do_reset();
        mv_q = '{0};
        do_capture(1, 1'b1);
        do_replay();
        chk("up.y", 32'(y_pos), 15);
        chk("up.perr", 32'(pos_err), 1);
        chk("up.done", 32'(replay_done), 1);

        // path exactly DEPTH long, last flagged on the final slot
        do_reset();
        mv_q = {};
        repeat (DEPTH) mv_q.push_back(int'($urandom_range(0, 3)));
        do_capture(DEPTH, 1'b1);
        chk("full.len", 32'(path_len), DEPTH);
        chk("full.ovf", 32'(overflow), 0);
        chk("full.fail", 32'(fail), 0);
        do_replay();

        // random paths
        repeat (8) begin
            do_reset();
            n = int'($urandom_range(1, DEPTH));
            mv_q = {};
            repeat (n) mv_q.push_back(int'($urandom_range(0, 3)));
            do_capture(n, 1'b1);
            chk("rnd.len", 32'(path_len), 32'(n));
            do_replay();
            if ($urandom_range(0, 1) == 1) do_replay();
        end

        // asynchronous reset in the middle of a replay
        do_reset();
        mv_q = '{1, 1, 3};
        do_capture(3, 1'b1);
        replay_start = 1'b1;
        @(negedge clk);
        replay_start = 1'b0;
        repeat (S + 1) @(negedge clk);
        chk("mid.x_before", 32'(x_pos), 1);
        chk("mid.led_before", 32'(led_dir), 4'b0010);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("mid");
        @(negedge clk);
        rst = 1'b1;
        err_sticky = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mid.idle_run", 32'(run), 0);
            chk("mid.idle_busy", 32'(busy), 0);
        end
        mv_q = '{2};
        do_capture(1, 1'b1);
        do_replay();
        chk("mid.x_wrap", 32'(x_pos), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
